fp_mul_pipe: RTL and testbench

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_mul_pipe.sv | 159 +++++++++++++++
 tb/tb_fp_mul_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// Purpose: pipelined IEEE-754 style multiplier, round-nearest-even, subnormals flushed to zero.
// Latency: 3 cycles from accepted operands to valid_out; one result per cycle.
// Backpressure: all stages hold while valid_out && !ready_out; ready_in drops in that case.
module fp_mul_pipe #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         valid_in,
    output logic         ready_in,
    output logic [W-1:0] out,
    output logic         valid_out,
    input  logic         ready_out,
    output logic [2:0]   flags
);

    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;
    localparam logic [EW2-1:0] BIAS = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [EW2-1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic [W-1:0]   QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_t;

    logic advance;
    assign advance  = !valid_out || ready_out;
    assign ready_in = advance;

    // ---------------- S1: unpack, classify, exponent sum ----------------
    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] frac_a, frac_b;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EW2-1:0]   exp_sum;
    kind_t            kind_n;

    assign {sign_a, exp_a, frac_a} = in_a;
    assign {sign_b, exp_b, frac_b} = in_b;
    // exp == 0 covers both true zero and flushed subnormals
    assign a_zero  = (exp_a == '0);
    assign b_zero  = (exp_b == '0);
    assign a_inf   = (&exp_a) && (frac_a == '0);
    assign b_inf   = (&exp_b) && (frac_b == '0);
    assign a_nan   = (&exp_a) && (frac_a != '0);
    assign b_nan   = (&exp_b) && (frac_b != '0);
    assign exp_sum = {2'b00, exp_a} + {2'b00, exp_b} - BIAS;

    always_comb begin
        kind_n = K_NORM;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            kind_n = K_NAN;
        else if (a_inf || b_inf)
            kind_n = K_INF;
        else if (a_zero || b_zero)
            kind_n = K_ZERO;
    end

    logic           s1_vld, s1_sign;
    kind_t          s1_kind;
    logic [EW2-1:0] s1_exp;
    logic [MAN_W:0] s1_man_a, s1_man_b;

    always_ff @(posedge clk) begin
        if (reset)        s1_vld <= 1'b0;
        else if (advance) s1_vld <= valid_in;
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_sign  <= sign_a ^ sign_b;
            s1_kind  <= kind_n;
            s1_exp   <= exp_sum;
            s1_man_a <= {1'b1, frac_a};
            s1_man_b <= {1'b1, frac_b};
        end
    end

    // ---------------- S2: mantissa multiply ----------------
    logic           s2_vld, s2_sign;
    kind_t          s2_kind;
    logic [EW2-1:0] s2_exp;
    logic [PW-1:0]  s2_prod;

    always_ff @(posedge clk) begin
        if (reset)        s2_vld <= 1'b0;
        else if (advance) s2_vld <= s1_vld;
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s2_sign <= s1_sign;
            s2_kind <= s1_kind;
            s2_exp  <= s1_exp;
            s2_prod <= {{(MAN_W+1){1'b0}}, s1_man_a} * {{(MAN_W+1){1'b0}}, s1_man_b};
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic             msb, guard, rnd, sticky, round_up;
    logic [PW-1:0]    norm;
    logic [MAN_W:0]   mant;
    logic [MAN_W+1:0] mant_r;
    logic [EW2-1:0]   e_fin;
    logic [W-1:0]     res;
    logic [2:0]       res_flags;

    // Left-justify so the leading one always sits at bit PW-1
    assign msb      = s2_prod[PW-1];
    assign norm     = msb ? s2_prod : {s2_prod[PW-2:0], 1'b0};
    assign mant     = norm[PW-1 -: MAN_W+1];
    assign guard    = norm[MAN_W];
    assign rnd      = norm[MAN_W-1];
    assign sticky   = |norm[MAN_W-2:0];
    assign round_up = guard && (rnd || sticky || mant[0]);
    assign mant_r   = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
    // A rounding carry leaves the fraction field all zero, so only the exponent moves
    assign e_fin    = s2_exp + {{(EW2-1){1'b0}}, msb} + {{(EW2-1){1'b0}}, mant_r[MAN_W+1]};

    always_comb begin
        res       = {s2_sign, e_fin[EXP_W-1:0], mant_r[MAN_W-1:0]};
        res_flags = 3'b000;
        case (s2_kind)
            K_NAN: begin
                res       = QNAN;
                res_flags = 3'b100;
            end
            K_INF:  res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            K_ZERO: res = {s2_sign, {(W-1){1'b0}}};
            default: begin
                if (!e_fin[EW2-1] && (e_fin >= EMAX)) begin
                    res       = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    res_flags = 3'b010;
                end else if (e_fin[EW2-1] || (e_fin == '0)) begin
                    res       = {s2_sign, {(W-1){1'b0}}};
                    res_flags = 3'b001;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            out       <= '0;
            flags     <= 3'b000;
        end else if (advance) begin
            valid_out <= s2_vld;
            if (s2_vld) begin
                out   <= res;
                flags <= res_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: vector table, backpressure stream, mid-flight reset,
// and a half-precision (EXP_W=5, MAN_W=10) instance.
module tb_fp_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] in_a, in_b, out;
    logic        valid_in, ready_in, valid_out, ready_out;
    logic [2:0]  flags;

    fp_mul_pipe dut (
        .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b),
        .valid_in(valid_in), .ready_in(ready_in), .out(out),
        .valid_out(valid_out), .ready_out(ready_out), .flags(flags)
    );

    logic [15:0] h_a, h_b, h_out;
    logic        h_valid_in, h_ready_in, h_valid_out, h_ready_out;
    logic [2:0]  h_flags;

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .in_a(h_a), .in_b(h_b),
        .valid_in(h_valid_in), .ready_in(h_ready_in), .out(h_out),
        .valid_out(h_valid_out), .ready_out(h_ready_out), .flags(h_flags)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    localparam int NV = 20;
    localparam int NH = 3;
    vec_t vecs[NV];
    vec_t hvecs[NH];

    logic [31:0] bp_a[5];
    logic [31:0] bp_exp[5];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 3'b000};
        vecs[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000};
        vecs[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000};
        vecs[3]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000};
        vecs[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010};
        vecs[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100};
        vecs[6]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b001};
        vecs[7]  = '{32'h00400000, 32'h3F800000, 32'h00000000, 3'b000};
        vecs[8]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b000};
        vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
        vecs[10] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b100};
        vecs[11] = '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 3'b000}; // tie, round up to even
        vecs[12] = '{32'h3FC00000, 32'h3F800003, 32'h3FC00004, 3'b000}; // tie, stays even
        vecs[13] = '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 3'b000}; // rounding carry-out
        vecs[14] = '{32'hC0000000, 32'hC0400000, 32'h40C00000, 3'b000};
        vecs[15] = '{32'h80000000, 32'hFF800000, 32'h7FC00000, 3'b100};
        vecs[16] = '{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000};
        vecs[17] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010};
        vecs[18] = '{32'h7E800000, 32'h40000000, 32'h7F000000, 3'b000};
        vecs[19] = '{32'h80400000, 32'h3F800000, 32'h80000000, 3'b000};

        hvecs[0] = '{32'h4000, 32'h4200, 32'h4600, 3'b000};
        hvecs[1] = '{32'h3E00, 32'h3E00, 32'h4080, 3'b000};
        hvecs[2] = '{32'h7800, 32'h7800, 32'h7C00, 3'b010};

        bp_a[0] = 32'h3F800000; bp_exp[0] = 32'h40000000;
        bp_a[1] = 32'h40000000; bp_exp[1] = 32'h40800000;
        bp_a[2] = 32'h40400000; bp_exp[2] = 32'h40C00000;
        bp_a[3] = 32'h40800000; bp_exp[3] = 32'h41000000;
        bp_a[4] = 32'h40A00000; bp_exp[4] = 32'h41200000;

        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1; in_a = '0; in_b = '0;
        h_valid_in = 1'b0; h_ready_out = 1'b1; h_a = '0; h_b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_ready_in", 32'(ready_in), 32'd1);
        check("rst_h_valid_out", 32'(h_valid_out), 32'd0);

        // Single-shot vectors: accept on one edge, result exactly 3 edges later
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            in_a = vecs[i].a; in_b = vecs[i].b; valid_in = 1'b1;
            @(posedge clk); #1;
            valid_in = 1'b0;
            @(posedge clk); #1;
            check($sformatf("v%0d_early", i), 32'(valid_out), 32'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_valid", i), 32'(valid_out), 32'd1);
            check($sformatf("v%0d_out", i), out, vecs[i].res);
            check($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].flg));
        end

        for (int i = 0; i < NH; i++) begin
            @(posedge clk); #1;
            h_a = hvecs[i].a[15:0]; h_b = hvecs[i].b[15:0]; h_valid_in = 1'b1;
            @(posedge clk); #1;
            h_valid_in = 1'b0;
            @(posedge clk); #1;
            check($sformatf("h%0d_early", i), 32'(h_valid_out), 32'd0);
            @(posedge clk); #1;
            check($sformatf("h%0d_valid", i), 32'(h_valid_out), 32'd1);
            check($sformatf("h%0d_out", i), 32'(h_out), hvecs[i].res);
            check($sformatf("h%0d_flags", i), 32'(h_flags), 32'(hvecs[i].flg));
        end

        // Backpressure: 5 back-to-back operands, ready_out low in cycles 2..6
        begin
            int          sent, got, stall_seen;
            logic        prev_stall;
            logic [31:0] prev_out;
            sent = 0; got = 0; stall_seen = 0; prev_stall = 1'b0; prev_out = '0;
            @(posedge clk); #1;
            for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
                if (cyc > 0) begin
                    @(posedge clk); #1;
                end
                ready_out = !(cyc >= 2 && cyc <= 6);
                if (sent < 5) begin
                    valid_in = 1'b1; in_a = bp_a[sent]; in_b = 32'h40000000;
                end else begin
                    valid_in = 1'b0;
                end
                @(negedge clk);
                if (prev_stall) begin
                    check($sformatf("bp_hold_valid_c%0d", cyc), 32'(valid_out), 32'd1);
                    check($sformatf("bp_hold_out_c%0d", cyc), out, prev_out);
                end
                if (valid_out && !ready_out) begin
                    check($sformatf("bp_ready_in_c%0d", cyc), 32'(ready_in), 32'd0);
                    stall_seen++;
                end
                if (valid_out && ready_out) begin
                    check($sformatf("bp_res%0d", got), out, bp_exp[got]);
                    got++;
                end
                if (valid_in && ready_in) sent++;
                prev_stall = valid_out && !ready_out;
                prev_out   = out;
            end
            check("bp_count", 32'(got), 32'd5);
            check("bp_stall_cycles", 32'(stall_seen), 32'd4);
            ready_out = 1'b1; valid_in = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check($sformatf("bp_no_dup%0d", k), 32'(valid_out), 32'd0);
            end
        end

        // Mid-flight reset: two operations accepted, then one reset cycle
        @(posedge clk); #1;
        valid_in = 1'b1; in_a = 32'h40000000; in_b = 32'h40400000;
        @(posedge clk); #1;
        in_a = 32'h3FC00000; in_b = 32'h3FC00000;
        @(posedge clk); #1;
        valid_in = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("mr_ready_in_during", 32'(ready_in), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("mr_valid%0d", k), 32'(valid_out), 32'd0);
            check($sformatf("mr_out%0d", k), out, 32'd0);
            check($sformatf("mr_ready_in%0d", k), 32'(ready_in), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
